serial_rx_wb: RTL

SERIAL_RX_WB -- requirements
Module: serial_rx_wb

---
 rtl/serial_rx_wb.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_rx_wb.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_wb
// Description : UART receiver with a small receive FIFO, exposed as a
//               two-register Wishbone (pipelined-mode) slave.
//               DATA   (addr bit2 = 0): {not_empty, 23'b0, char[7:0]}, pops
//               STATUS (addr bit2 = 1): {16'b0, count, 5'b0, frame_err,
//                                        overrun, not_empty}
//               Write STATUS bit1 clears overrun, bit2 clears frame_err.
//               Optional macro SERIAL_RX_SYNC_EN inserts a 2-flop input
//               synchronizer on uart_rx (2 cycles extra latency).
//               Count field is 8 bits wide, so DEPTH is limited to 128.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx_wb #(
    parameter int DIVIDE = 2,
    parameter int FRAME  = 8,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_data_w,
    output logic [31:0] wb_data_r,
    input  logic        wb_we,
    input  logic        wb_stb,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        wb_stall
);

    localparam int               c_aw        = $clog2(DEPTH);
    localparam int               c_cw        = c_aw + 1;
    localparam logic [15:0]      c_div_last  = 16'(DIVIDE - 1);
    localparam logic [15:0]      c_half_last = 16'(DIVIDE / 2 - 1);
    localparam logic [3:0]       c_frame_last = 4'(FRAME - 1);
    localparam logic [c_cw-1:0]  c_depth     = c_cw'(DEPTH);
    localparam logic [c_cw-1:0]  c_cnt_one   = c_cw'(1);
    localparam logic [c_aw-1:0]  c_ptr_one   = c_aw'(1);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_start = 3'd1;
    localparam logic [2:0] c_data  = 3'd2;
    localparam logic [2:0] c_stop  = 3'd3;
    localparam logic [2:0] c_break = 3'd4;

    logic             w_rx;
    logic [2:0]       r_state, w_state_next;
    logic [15:0]      r_div;
    logic [3:0]       r_bit;
    logic [FRAME-1:0] r_shift;
    logic             w_sample, w_shift_en, w_push, w_frame_set;

    logic [7:0]       r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             r_overrun, r_frame_err;
    logic             r_ack;
    logic [31:0]      r_data_r;

    logic w_req, w_rd_data, w_rd_stat, w_wr_stat;
    logic w_empty, w_full, w_pop, w_wr, w_ovr_set;
    logic w_unused_bits;

`ifdef SERIAL_RX_SYNC_EN
    logic r_sync1, r_sync2;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx = r_sync2;
`else
    assign w_rx = uart_rx;
`endif

    // Receiver state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_idle;
        else     r_state <= w_state_next;
    end

    // Next-state and sample-point decode
    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_shift_en   = 1'b0;
        w_push       = 1'b0;
        w_frame_set  = 1'b0;
        case (r_state)
            c_idle: begin
                if (!w_rx) w_state_next = c_start;
            end
            c_start: begin
                if (r_div == c_half_last) begin
                    w_sample     = 1'b1;
                    w_state_next = w_rx ? c_idle : c_data;
                end
            end
            c_data: begin
                if (r_div == c_div_last) begin
                    w_sample   = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit == c_frame_last) w_state_next = c_stop;
                end
            end
            c_stop: begin
                if (r_div == c_div_last) begin
                    w_sample = 1'b1;
                    if (w_rx) begin
                        w_push       = 1'b1;
                        w_state_next = c_idle;
                    end else begin
                        w_frame_set  = 1'b1;
                        w_state_next = c_break;
                    end
                end
            end
            c_break: begin
                if (w_rx) w_state_next = c_idle;
            end
            default: w_state_next = c_idle;
        endcase
    end

    // Divide counter, bit counter and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= 16'd0;
            r_bit   <= 4'd0;
            r_shift <= '0;
        end else begin
            if ((r_state == c_start || r_state == c_data || r_state == c_stop) && !w_sample)
                r_div <= r_div + 16'd1;
            else
                r_div <= 16'd0;
            if (w_shift_en) begin
                r_bit   <= r_bit + 4'd1;
                r_shift <= {w_rx, r_shift[FRAME-1:1]};
            end else if (r_state != c_data) begin
                r_bit <= 4'd0;
            end
        end
    end

    assign w_req     = wb_stb & wb_cyc;
    assign w_rd_data = w_req & ~wb_we & ~wb_addr[2];
    assign w_rd_stat = w_req & ~wb_we &  wb_addr[2];
    assign w_wr_stat = w_req &  wb_we &  wb_addr[2];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign w_pop     = w_rd_data & ~w_empty;
    // A full FIFO still accepts a push when a pop frees the slot this cycle
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovr_set = w_push & w_full & ~w_pop;

    // FIFO storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_wr && !rst) r_mem[r_wr_ptr] <= 8'(r_shift);
    end

    // FIFO pointers, occupancy and sticky error flags (set wins over clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
            if (w_wr && !w_pop)      r_count <= r_count + c_cnt_one;
            else if (w_pop && !w_wr) r_count <= r_count - c_cnt_one;
            r_overrun   <= (r_overrun   & ~(w_wr_stat & wb_data_w[1])) | w_ovr_set;
            r_frame_err <= (r_frame_err & ~(w_wr_stat & wb_data_w[2])) | w_frame_set;
        end
    end

    // Registered Wishbone response; data is zero whenever ack is low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack    <= 1'b0;
            r_data_r <= 32'd0;
        end else begin
            r_ack <= w_req;
            if (w_rd_data && !w_empty)
                r_data_r <= {1'b1, 23'd0, r_mem[r_rd_ptr]};
            else if (w_rd_stat)
                r_data_r <= {16'd0, 8'(r_count), 5'd0, r_frame_err, r_overrun, ~w_empty};
            else
                r_data_r <= 32'd0;
        end
    end

    assign wb_ack    = r_ack;
    assign wb_data_r = r_data_r;
    assign wb_stall  = 1'b0;

    assign w_unused_bits = ^{wb_addr[31:3], wb_addr[1:0], wb_data_w[31:3], wb_data_w[0]};

endmodule
`default_nettype wire
